// File: rtl/fdq_pkg.sv
// rtl/fdq_pkg.sv - shared entry layout and constants for the fetch/decode packet queue
package fdq_pkg;

    localparam int FDQ_PKT_W = 128;
    localparam int ENTRY_W   = FDQ_PKT_W + 49;

    // Exception type encodings carried in IE_type
    localparam logic [3:0] IE_PROT     = 4'b0001;
    localparam logic [3:0] IE_TLB_MISS = 4'b0010;

    // One queue slot: packet plus side-band; spare bits pad the slot to ENTRY_W
    typedef struct packed {
        logic [FDQ_PKT_W-1:0] packet;
        logic                 is_br_t_nt;
        logic [31:0]          bp_target;
        logic [5:0]           bp_update_alias;
        logic                 ie;
        logic [3:0]           ie_type;
        logic                 is_idtr;
        logic                 is_pop_eflags;
        logic [2:0]           spare;
    } fdq_entry_t;

endpackage

// File: rtl/fdq_ctrl.sv
// rtl/fdq_ctrl.sv - pointers, occupancy, exception block and stall for the packet queue
module fdq_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_IE,
    input  logic             dec_ready,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             wr_en,
    output logic             empty,
    output logic             bypass,
    output logic             stall,
    output logic             ie_block
);
    import fdq_pkg::*;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic full;
    logic accept;
    logic pop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign accept = in_valid & ~full & ~ie_block & ~flush;
    // Bypass only exists when the queue is empty, so head and tail agree
    assign bypass = BYPASS_EN & empty & accept;
    assign pop    = dec_ready & ~empty;
    // A bypassed packet consumed in the same cycle never occupies a slot
    assign wr_en  = accept & ~(bypass & dec_ready);
    // Built from registers only, so fetch sees no path from dec_ready/in_valid
    assign stall  = full | ie_block;

    // Pointer, occupancy and exception-block state; flush behaves like reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ie_block <= 1'b0;
        end else begin
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && in_IE) begin
                ie_block <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fd_packet_queue.sv
// rtl/fd_packet_queue.sv - fetch-to-decode packet queue top; FDQ_BYPASS_EN enables empty-queue bypass
module fd_packet_queue
    import fdq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PKT_W = FDQ_PKT_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PKT_W-1:0] in_packet,
    input  logic             in_is_BR_T_NT,
    input  logic [31:0]      in_BP_target,
    input  logic [5:0]       in_BP_update_alias,
    input  logic             in_IE,
    input  logic [3:0]       in_IE_type,
    input  logic             in_is_IDTR,
    input  logic             in_is_POP_EFLAGS,
    input  logic             dec_ready,
    output logic             stall_fetch,
    output logic             out_valid,
    output logic [PKT_W-1:0] out_packet,
    output logic             out_is_BR_T_NT,
    output logic [31:0]      out_BP_target,
    output logic [5:0]       out_BP_update_alias,
    output logic             out_IE,
    output logic             out_IE_type_unused_guard_n,
    output logic [3:0]       out_IE_type,
    output logic             out_is_IDTR,
    output logic             out_is_POP_EFLAGS,
    output logic [PTR_W:0]   count,
    output logic             ie_block
);

`ifdef FDQ_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               wr_en;
    logic               empty;
    logic               bypass;
    fdq_entry_t         in_e;
    fdq_entry_t         out_e;

    fdq_ctrl #(
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_IE     (in_IE),
        .dec_ready (dec_ready),
        .head      (head),
        .tail      (tail),
        .count     (count),
        .wr_en     (wr_en),
        .empty     (empty),
        .bypass    (bypass),
        .stall     (stall_fetch),
        .ie_block  (ie_block)
    );

    // Pack the incoming packet and side-band into one slot image
    always_comb begin
        in_e                 = '0;
        in_e.packet          = in_packet;
        in_e.is_br_t_nt      = in_is_BR_T_NT;
        in_e.bp_target       = in_BP_target;
        in_e.bp_update_alias = in_BP_update_alias;
        in_e.ie              = in_IE;
        in_e.ie_type         = in_IE_type;
        in_e.is_idtr         = in_is_IDTR;
        in_e.is_pop_eflags   = in_is_POP_EFLAGS;
    end

    // Slot storage; contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= in_e;
        end
    end

    // Head view: stored head, else the bypassed input, else all zeros
    always_comb begin
        out_e = '0;
        if (!empty) begin
            out_e = fdq_entry_t'(mem[head]);
        end else if (bypass) begin
            out_e = in_e;
        end
        out_valid = ~empty | bypass;
    end

    assign out_packet                 = out_e.packet;
    assign out_is_BR_T_NT             = out_e.is_br_t_nt;
    assign out_BP_target              = out_e.bp_target;
    assign out_BP_update_alias        = out_e.bp_update_alias;
    assign out_IE                     = out_e.ie;
    assign out_IE_type                = out_e.ie_type;
    assign out_is_IDTR                = out_e.is_idtr;
    assign out_is_POP_EFLAGS          = out_e.is_pop_eflags;
    assign out_IE_type_unused_guard_n = |out_e.spare;

endmodule

// File: tb/tb_fd_packet_queue.sv
// tb/tb_fd_packet_queue.sv - self-checking bench for fd_packet_queue
module tb_fd_packet_queue;

    localparam int DEPTH = 4;
`ifdef FDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] packet;
        logic         br;
        logic [31:0]  tgt;
        logic [5:0]   bp_alias;
        logic         ie;
        logic [3:0]   ie_type;
        logic         idtr;
        logic         popf;
    } ent_t;

    typedef struct {
        bit         rst, fl, iv, ie, dr;
        logic [3:0] tag;
        int         cnt;
        bit         ov;
        logic [3:0] eh;
        bit         st, ieb, oie;
    } vec_t;

    logic         clk;
    logic         reset, flush, in_valid, dec_ready;
    logic [127:0] in_packet;
    logic         in_is_BR_T_NT, in_IE, in_is_IDTR, in_is_POP_EFLAGS;
    logic [31:0]  in_BP_target;
    logic [5:0]   in_BP_update_alias;
    logic [3:0]   in_IE_type;
    logic         stall_fetch, out_valid, out_is_BR_T_NT, out_IE, out_is_IDTR, out_is_POP_EFLAGS;
    logic         spare_or;
    logic [127:0] out_packet;
    logic [31:0]  out_BP_target;
    logic [5:0]   out_BP_update_alias;
    logic [3:0]   out_IE_type;
    logic [2:0]   count;
    logic         ie_block;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    ent_t q[$];
    bit   m_ieb;

    fd_packet_queue dut (
        .clk                        (clk),
        .reset                      (reset),
        .flush                      (flush),
        .in_valid                   (in_valid),
        .in_packet                  (in_packet),
        .in_is_BR_T_NT              (in_is_BR_T_NT),
        .in_BP_target               (in_BP_target),
        .in_BP_update_alias         (in_BP_update_alias),
        .in_IE                      (in_IE),
        .in_IE_type                 (in_IE_type),
        .in_is_IDTR                 (in_is_IDTR),
        .in_is_POP_EFLAGS           (in_is_POP_EFLAGS),
        .dec_ready                  (dec_ready),
        .stall_fetch                (stall_fetch),
        .out_valid                  (out_valid),
        .out_packet                 (out_packet),
        .out_is_BR_T_NT             (out_is_BR_T_NT),
        .out_BP_target              (out_BP_target),
        .out_BP_update_alias        (out_BP_update_alias),
        .out_IE                     (out_IE),
        .out_IE_type_unused_guard_n (spare_or),
        .out_IE_type                (out_IE_type),
        .out_is_IDTR                (out_is_IDTR),
        .out_is_POP_EFLAGS          (out_is_POP_EFLAGS),
        .count                      (count),
        .ie_block                   (ie_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit rst, input bit fl, input bit iv, input bit dr, input ent_t e);
        reset              = rst;
        flush              = fl;
        in_valid           = iv;
        dec_ready          = dr;
        in_packet          = e.packet;
        in_is_BR_T_NT      = e.br;
        in_BP_target       = e.tgt;
        in_BP_update_alias = e.bp_alias;
        in_IE              = e.ie;
        in_IE_type         = e.ie_type;
        in_is_IDTR         = e.idtr;
        in_is_POP_EFLAGS   = e.popf;
    endtask

    function automatic ent_t dut_out();
        ent_t o;
        o.packet   = out_packet;
        o.br       = out_is_BR_T_NT;
        o.tgt      = out_BP_target;
        o.bp_alias = out_BP_update_alias;
        o.ie       = out_IE;
        o.ie_type  = out_IE_type;
        o.idtr     = out_is_IDTR;
        o.popf     = out_is_POP_EFLAGS;
        return o;
    endfunction

    function automatic ent_t mk(input logic [127:0] p, input bit ie);
        ent_t e = '0;
        e.packet  = p;
        e.ie      = ie;
        e.ie_type = ie ? 4'b0010 : 4'b0000;
        return e;
    endfunction

    // one clock: drive at negedge, let the edge pass, return inputs to idle
    task automatic step(input bit rst, input bit fl, input bit iv, input bit dr, input ent_t e);
        @(negedge clk);
        set_in(rst, fl, iv, dr, e);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
    endtask

    task automatic addv(input bit rst, input bit fl, input bit iv, input bit ie, input bit dr,
                        input logic [3:0] tag, input int cnt, input bit ov, input logic [3:0] eh,
                        input bit st, input bit ieb, input bit oie);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ie = ie; v.dr = dr; v.tag = tag;
        v.cnt = cnt; v.ov = ov; v.eh = eh; v.st = st; v.ieb = ieb; v.oie = oie;
        tbl.push_back(v);
    endtask

    initial begin
        ent_t e;
        ent_t exp_e;
        bit   rst_r, fl_r, iv_r, dr_r, acc;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);

        //   rst fl iv ie dr tag  cnt ov head st ieb oie
        addv(1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hA, 1, 1, 4'hA, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hB, 2, 1, 4'hA, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hC, 3, 1, 4'hA, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 2, 1, 4'hB, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 1, 1, 4'hC, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h1, 1, 1, 4'h1, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h2, 2, 1, 4'h1, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h3, 3, 1, 4'h1, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h4, 4, 1, 4'h1, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h5, 4, 1, 4'h1, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 3, 1, 4'h2, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h5, 4, 1, 4'h2, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 3, 1, 4'h3, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 2, 1, 4'h4, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 1, 1, 4'h5, 0, 0, 0);
        addv(0, 0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 1, 0, 4'h6, 1, 1, 4'h6, 1, 1, 1);
        addv(0, 0, 1, 0, 0, 4'h7, 1, 1, 4'h6, 1, 1, 1);
        addv(0, 0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 1, 1, 0);
        addv(0, 0, 1, 0, 0, 4'h8, 0, 0, 4'h0, 1, 1, 0);
        addv(0, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h9, 1, 1, 4'h9, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hA, 2, 1, 4'h9, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hB, 3, 1, 4'h9, 0, 0, 0);
        addv(0, 1, 1, 0, 0, 4'hC, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hD, 1, 1, 4'hD, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'hE, 2, 1, 4'hD, 0, 0, 0);
        addv(1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 4'h3, 1, 1, 4'h3, 0, 0, 0);
        addv(1, 0, 1, 0, 0, 4'hF, 0, 0, 4'h0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].dr, mk({tbl[i].tag, 124'b0}, tbl[i].ie));
            chk($sformatf("row%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("row%0d_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("row%0d_packet", i), out_packet, tbl[i].ov ? {tbl[i].eh, 124'b0} : 128'b0);
            chk($sformatf("row%0d_stall", i), stall_fetch, tbl[i].st);
            chk($sformatf("row%0d_ieblock", i), ie_block, tbl[i].ieb);
            chk($sformatf("row%0d_ie", i), out_IE, tbl[i].oie);
            chk($sformatf("row%0d_ietype", i), out_IE_type, tbl[i].oie ? 4'b0010 : 4'b0000);
        end

        // steady push+pop at count 2 across several pointer wraps
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(128'd100, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(128'd101, 1'b0));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, mk(128'(102 + i), 1'b0));
            chk("wrap_count", count, 2);
            chk("wrap_head", out_packet, 128'(101 + i));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // empty queue, packet offered while decode is ready
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, mk(128'hE0, 1'b0));
        #1;
        chk("byp_same_valid", out_valid, BYP);
        chk("byp_same_packet", out_packet, BYP ? 128'hE0 : 128'h0);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("byp_next_count", count, BYP ? 3'd0 : 3'd1);
        chk("byp_next_valid", out_valid, !BYP);
        chk("byp_next_packet", out_packet, BYP ? 128'h0 : 128'hE0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // randomized traffic against a queue-based reference
        q.delete();
        m_ieb = 1'b0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rst_r = ($urandom_range(0, 199) == 0);
            fl_r  = ($urandom_range(0, 39) == 0);
            iv_r  = ($urandom_range(0, 3) != 0);
            dr_r  = ($urandom_range(0, 2) == 0);
            e.packet   = {$urandom, $urandom, $urandom, $urandom};
            e.br       = 1'($urandom);
            e.tgt      = $urandom;
            e.bp_alias = 6'($urandom);
            e.ie       = ($urandom_range(0, 29) == 0);
            e.ie_type  = 4'($urandom);
            e.idtr     = 1'($urandom);
            e.popf     = 1'($urandom);
            set_in(rst_r, fl_r, iv_r, dr_r, e);
            #1;
            if (q.size() > 0)                          exp_e = q[0];
            else if (BYP && iv_r && !m_ieb && !fl_r)   exp_e = e;
            else                                       exp_e = '0;
            chk("rnd_valid", out_valid, (q.size() > 0) || (BYP && iv_r && !m_ieb && !fl_r));
            chk("rnd_head", dut_out(), exp_e);
            chk("rnd_count", count, q.size());
            chk("rnd_stall", stall_fetch, (q.size() == DEPTH) || m_ieb);
            chk("rnd_ieblock", ie_block, m_ieb);
            @(posedge clk);
            if (rst_r || fl_r) begin
                q.delete();
                m_ieb = 1'b0;
            end else begin
                acc = iv_r && (q.size() < DEPTH) && !m_ieb;
                if (BYP && acc && dr_r && q.size() == 0) begin
                    // consumed straight through, nothing stored
                end else begin
                    if (dr_r && q.size() > 0) void'(q.pop_front());
                    if (acc) q.push_back(e);
                end
                if (acc && e.ie) m_ieb = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_packet_queue.md
Name: fd_packet_queue

Overview:
- Decoupling queue between fetch stage 2 and decode.
- Buffers 128-bit instruction packets with their side-band data: branch-prediction info, exception info, IDTR origin and POP_EFLAGS flag.
- Generates the `stall` seen by fetch and absorbs decode back-pressure.
- Flushed on resteer.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PKT_W, 128, packet width in bits.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  resteer/WB flush; empties queue
- in_valid  in  1  fetch packet valid
- in_packet  in  PKT_W  fetch packet
- in_is_BR_T_NT  in  1  predicted-taken flag
- in_BP_target  in  32  predicted target
- in_BP_update_alias  in  6  BP alias
- in_IE  in  1  fetch exception (TLB miss / protection)
- in_IE_type  in  4  exception type
- in_is_IDTR  in  1  packet originates from IDTR
- in_is_POP_EFLAGS  in  1  IDTR POP_EFLAGS marker
- dec_ready  in  1  decode consumes head this cycle
- stall_fetch  out  1  fetch must hold its packet
- out_valid  out  1  head entry valid
- out_packet  out  PKT_W  head packet
- out_is_BR_T_NT  out  1  head side-band
- out_BP_target  out  32  head side-band
- out_BP_update_alias  out  6  head side-band
- out_IE  out  1  head side-band
- out_IE_type  out  4  head side-band
- out_is_IDTR  out  1  head side-band
- out_is_POP_EFLAGS  out  1  head side-band
- count  out  PTR_W+1  occupancy
- ie_block  out  1  exception entry queued; pushes blocked

Behaviour:
- Storage: DEPTH entries × (PKT_W+49) bits. Head pointer and tail pointer are PTR_W bits and wrap modulo DEPTH. Occupancy counter is PTR_W+1 bits.
- Definitions:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - pop = dec_ready & out_valid
  - push = in_valid & ~full & ~ie_block & ~flush
- stall_fetch = full | ie_block. It is derived from registered state only; there is no combinational path from dec_ready or in_valid.
- Push: write entry at tail; tail ← tail+1.
- Pop: head ← head+1.
- Count update:
  - push & pop: unchanged. Legal when full is 0.
  - push only: +1.
  - pop only: −1.
- Full with dec_ready=1: pop occurs, push is refused that cycle, stall_fetch deasserts next cycle.
- Latency: pushed entry is visible at the outputs the next cycle.
- out_valid = ~empty. out_* fields are driven from the head entry. When empty, out_* fields are 0.
- ie_block:
  - Set on a push with in_IE=1.
  - Cleared only by flush or reset.
  - While set, no further pushes are accepted; the exception packet and older entries still drain.
- Flush:
  - Next cycle: head=tail=count=0, ie_block=0, out_valid=0.
  - Flush has priority over a push or pop in the same cycle; both are discarded.
  - Storage contents need not be cleared.
- Reset: same end state as flush. Every output reads 0 the cycle after reset.
- Reset asserted mid-stream: all in-flight entries are lost; no partial state persists.
- Wrap-around: the pointers wrap transparently; DEPTH consecutive push/pop pairs leave count unchanged.

Optional Feature:
- Macro FDQ_BYPASS_EN.
- Defined: when empty & in_valid & ~ie_block & ~flush, the incoming packet and side-band data are driven combinationally to out_*, and out_valid=1 the same cycle.
  - If dec_ready=1 that cycle, the packet is consumed without being written and count is unchanged.
  - Otherwise it is written normally.
- Undefined: fixed 1-cycle latency as described above.

Decomposition:
- Shared package fdq_pkg holds:
  - the entry struct (packet, BR_T_NT, target, alias, IE, IE_type, IDTR, POP_EFLAGS);
  - the ENTRY_W constant = PKT_W+49;
  - the IE_type encodings (bit0 protection, bit1 TLB miss).
- One natural sub-module: fdq_ctrl, covering pointers, count, full/empty, ie_block and stall. The storage array remains in the top module.

Test Plan:
1. Reset, then push packets 0xA..0, 0xB..0, 0xC..0 with dec_ready=0 → count=3, stall_fetch=0. Set dec_ready=1 → outputs A, B, C in order, then out_valid=0.
2. Push 4 with dec_ready=0 → count=4, stall_fetch=1; 5th in_valid refused. One pop → count=3 and stall_fetch=0 the next cycle; the 5th packet is then accepted.
3. Simultaneous push and pop at count=2 for 10 cycles → count stays 2, and the pointers wrap cleanly.
4. Push with in_IE=1, in_IE_type=4'b0010 → ie_block=1, stall_fetch=1, and the next packets are refused. The exception entry still drains with out_IE=1 and IE_type=2. Flush → ie_block=0.
5. Queue holding 3 entries; flush and in_valid asserted the same cycle → next cycle count=0, out_valid=0, and the incoming packet is not stored.
6. With FDQ_BYPASS_EN: queue empty, in_valid=1, dec_ready=1 → out_valid=1 and out_packet=in_packet the same cycle, with count staying 0. Without the macro: out_valid=1 one cycle later and count=1.
